// File: rtl/ps2_kbd_cmd_sequencer.sv
// Host-to-keyboard command sequencer: sends opcode/argument bytes through the PS/2 core,
// waits for ACK/resend/BAT responses and forwards every byte it does not consume.
module ps2_kbd_cmd_sequencer #(
    parameter int ACK_TIMEOUT = 2500000,
    parameter int BAT_TIMEOUT = 50000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_arg,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    output logic [7:0] the_command,
    output logic       send_command,
    input  logic       command_was_sent,
    input  logic       error_communication_timed_out,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic [7:0] key_byte,
    output logic       key_byte_en
);

    typedef enum logic [2:0] {
        IDLE, SEND_OP, WAIT_OP_ACK, SEND_ARG, WAIT_ARG_ACK, WAIT_BAT, FINISH, FAIL
    } state_t;

    localparam logic [25:0] ACK_LAST    = 26'(ACK_TIMEOUT - 1);
    localparam logic [25:0] BAT_LAST    = 26'(BAT_TIMEOUT - 1);
    localparam logic [1:0]  RETRY_LIMIT = 2'(MAX_RETRY);

    state_t      state, state_next;
    logic [25:0] timer;
    logic [1:0]  retry_cnt;
    logic [1:0]  op_q;
    logic [7:0]  arg_q;
    logic [1:0]  fail_code;
    logic        retry_inc;
    logic        consume;
    logic        rx_ack, rx_resend, rx_bat_ok, rx_bat_bad;

    function automatic logic [7:0] opcode(input logic [1:0] op);
        case (op)
            2'b00:   return 8'hED;
            2'b01:   return 8'hF3;
            2'b10:   return 8'hFF;
            default: return 8'hF4;
        endcase
    endfunction

    assign rx_ack     = received_data_en && (received_data == 8'hFA);
    assign rx_resend  = received_data_en && (received_data == 8'hFE);
    assign rx_bat_ok  = received_data_en && (received_data == 8'hAA);
    assign rx_bat_bad = received_data_en && (received_data == 8'hFC);

    assign busy         = (state == SEND_OP) || (state == WAIT_OP_ACK) || (state == SEND_ARG) ||
                          (state == WAIT_ARG_ACK) || (state == WAIT_BAT);
    assign done         = (state == FINISH);
    assign error        = (state == FAIL);
    assign send_command = (state == SEND_OP) || (state == SEND_ARG);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Bytes only count as responses in the WAIT states, so a byte arriving with
    // command_was_sent is judged under the SEND state and forwarded.
    always_comb begin
        state_next = state;
        fail_code  = 2'b00;
        retry_inc  = 1'b0;
        consume    = 1'b0;
        case (state)
            IDLE: if (req) state_next = SEND_OP;
            SEND_OP, SEND_ARG: begin
                if (command_was_sent) begin
                    state_next = (state == SEND_OP) ? WAIT_OP_ACK : WAIT_ARG_ACK;
                end else if (error_communication_timed_out) begin
                    state_next = FAIL;
                    fail_code  = 2'b01;
                end
            end
            WAIT_OP_ACK, WAIT_ARG_ACK: begin
                if (rx_ack) begin
                    consume = 1'b1;
                    if (state == WAIT_ARG_ACK) begin
                        state_next = FINISH;
                    end else begin
                        case (op_q)
                            2'b00, 2'b01: state_next = SEND_ARG;
                            2'b10:        state_next = WAIT_BAT;
                            default:      state_next = FINISH;
                        endcase
                    end
                end else if (rx_resend) begin
                    consume = 1'b1;
                    if (retry_cnt == RETRY_LIMIT) begin
                        state_next = FAIL;
                        fail_code  = 2'b11;
                    end else begin
                        retry_inc  = 1'b1;
                        state_next = (state == WAIT_OP_ACK) ? SEND_OP : SEND_ARG;
                    end
                end else if (timer == ACK_LAST) begin
                    state_next = FAIL;
                    fail_code  = 2'b10;
                end
            end
            WAIT_BAT: begin
                if (rx_bat_ok) begin
                    consume    = 1'b1;
                    state_next = FINISH;
                end else if (rx_bat_bad) begin
                    consume    = 1'b1;
                    state_next = FAIL;
                    fail_code  = 2'b11;
                end else if (timer == BAT_LAST) begin
                    state_next = FAIL;
                    fail_code  = 2'b10;
                end
            end
            FINISH, FAIL: state_next = IDLE;
            default:      state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            timer       <= '0;
            retry_cnt   <= '0;
            op_q        <= '0;
            arg_q       <= '0;
            err_code    <= '0;
            the_command <= '0;
            key_byte    <= '0;
            key_byte_en <= 1'b0;
        end else begin
            timer <= (state_next != state) ? '0 : timer + 26'd1;
            if (state == IDLE && req) begin
                op_q        <= cmd_op;
                arg_q       <= cmd_arg;
                retry_cnt   <= '0;
                err_code    <= 2'b00;
                the_command <= opcode(cmd_op);
            end else if (state_next == SEND_ARG) begin
                the_command <= arg_q;
            end
            if (retry_inc) retry_cnt <= retry_cnt + 2'd1;
            if (state_next == FAIL) err_code <= fail_code;
            key_byte_en <= received_data_en && !consume;
            if (received_data_en && !consume) key_byte <= received_data;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_cmd_sequencer.sv
// Self-checking bench for ps2_kbd_cmd_sequencer: a table of full command scenarios
// answered by a scripted core model, plus hand-written timing and reset sequences.
module tb_ps2_kbd_cmd_sequencer;

    logic       clock;
    logic       reset;
    logic       req;
    logic [1:0] cmd_op;
    logic [7:0] cmd_arg;
    logic       busy, done, error;
    logic [1:0] err_code;
    logic [7:0] the_command;
    logic       send_command;
    logic       command_was_sent;
    logic       error_communication_timed_out;
    logic [7:0] received_data;
    logic       received_data_en;
    logic [7:0] key_byte;
    logic       key_byte_en;

    int n_checks = 0;
    int n_fail   = 0;
    int done_total = 0, err_total = 0, fwd_total = 0;
    int overlap = 0, back_to_back = 0;
    logic prev_pulse = 1'b0;

    ps2_kbd_cmd_sequencer #(.ACK_TIMEOUT(100), .BAT_TIMEOUT(300), .MAX_RETRY(3)) dut (
        .clock(clock), .reset(reset), .req(req), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .the_command(the_command), .send_command(send_command),
        .command_was_sent(command_was_sent),
        .error_communication_timed_out(error_communication_timed_out),
        .received_data(received_data), .received_data_en(received_data_en),
        .key_byte(key_byte), .key_byte_en(key_byte_en)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (done) done_total++;
        if (error) err_total++;
        if (key_byte_en) fwd_total++;
        if (done && error) overlap++;
        if (prev_pulse && (done || error)) back_to_back++;
        prev_pulse = done || error;
    end

    typedef struct {
        logic [1:0] op;
        logic [7:0] arg;
        int         fe_op;
        int         fe_arg;
        logic [7:0] bat;
        logic       exp_done;
        logic [1:0] exp_code;
        int         exp_op_sends;
        int         exp_arg_sends;
    } cmd_vec_t;

    cmd_vec_t vecs[7];

    function automatic logic [7:0] exp_opcode(input logic [1:0] op);
        case (op)
            2'b00:   return 8'hED;
            2'b01:   return 8'hF3;
            2'b10:   return 8'hFF;
            default: return 8'hF4;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        received_data    = b;
        received_data_en = 1'b1;
        @(negedge clock);
        received_data_en = 1'b0;
    endtask

    task automatic start_cmd(input logic [1:0] op, input logic [7:0] arg);
        req     = 1'b1;
        cmd_op  = op;
        cmd_arg = arg;
        @(negedge clock);
        req = 1'b0;
    endtask

    task automatic wait_send(input string name);
        int cyc;
        cyc = 0;
        while (!send_command && cyc < 20) begin
            @(negedge clock);
            cyc++;
        end
        if (!send_command) check_output({name, "_send_timeout"}, 32'(send_command), 32'd1);
    endtask

    task automatic pulse_sent();
        command_was_sent = 1'b1;
        @(negedge clock);
        command_was_sent = 1'b0;
    endtask

    // Scripted core: acknowledges each transmit, answers with FE while resends remain,
    // then FA, and follows a reset ACK with the BAT byte.
    task automatic apply_stimulus(input cmd_vec_t v, output int op_sends, output int arg_sends,
                                  output int bad_bytes, output logic finished);
        int fe_op_left, fe_arg_left, budget;
        logic op_acked;
        fe_op_left  = v.fe_op;
        fe_arg_left = v.fe_arg;
        op_sends = 0; arg_sends = 0; bad_bytes = 0; budget = 0;
        op_acked = 1'b0;
        finished = 1'b0;
        start_cmd(v.op, v.arg);
        while (!finished && budget < 3000) begin
            if (done || error) begin
                finished = 1'b1;
            end else if (send_command) begin
                if (!op_acked) begin
                    op_sends++;
                    if (the_command !== exp_opcode(v.op)) bad_bytes++;
                end else begin
                    arg_sends++;
                    if (the_command !== v.arg) bad_bytes++;
                end
                pulse_sent();
                @(negedge clock);
                if (!op_acked && fe_op_left > 0) begin
                    fe_op_left--;
                    send_byte(8'hFE);
                end else if (op_acked && fe_arg_left > 0) begin
                    fe_arg_left--;
                    send_byte(8'hFE);
                end else begin
                    send_byte(8'hFA);
                    if (!op_acked && v.op == 2'b10) begin
                        @(negedge clock);
                        send_byte(v.bat);
                    end
                    op_acked = 1'b1;
                end
                budget += 5;
            end else begin
                @(negedge clock);
                budget++;
            end
        end
    endtask

    initial begin
        int op_sends, arg_sends, bad_bytes, d0, e0, f0, cyc;
        logic finished;

        vecs[0] = '{2'b00, 8'h07, 0, 0, 8'h00, 1'b1, 2'b00, 1, 1};
        vecs[1] = '{2'b10, 8'h00, 0, 0, 8'hAA, 1'b1, 2'b00, 1, 0};
        vecs[2] = '{2'b10, 8'h00, 0, 0, 8'hFC, 1'b0, 2'b11, 1, 0};
        vecs[3] = '{2'b01, 8'h20, 0, 2, 8'h00, 1'b1, 2'b00, 1, 3};
        vecs[4] = '{2'b01, 8'h20, 0, 4, 8'h00, 1'b0, 2'b11, 1, 4};
        vecs[5] = '{2'b11, 8'h00, 1, 0, 8'h00, 1'b1, 2'b00, 2, 0};
        vecs[6] = '{2'b00, 8'h55, 2, 2, 8'h00, 1'b0, 2'b11, 3, 2};

        reset = 1'b0; req = 1'b0; cmd_op = 2'b00; cmd_arg = 8'h00;
        command_was_sent = 1'b0; error_communication_timed_out = 1'b0;
        received_data = 8'h00; received_data_en = 1'b0;
        repeat (3) @(negedge clock);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_done_error", {30'd0, done, error}, 32'd0);
        check_output("rst_send_command", 32'(send_command), 32'd0);
        check_output("rst_key_byte_en", 32'(key_byte_en), 32'd0);
        check_output("rst_the_command", 32'(the_command), 32'h00);
        check_output("rst_key_byte", 32'(key_byte), 32'h00);
        check_output("rst_err_code", 32'(err_code), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 7; i++) begin
            d0 = done_total; e0 = err_total; f0 = fwd_total;
            apply_stimulus(vecs[i], op_sends, arg_sends, bad_bytes, finished);
            repeat (3) @(negedge clock);
            #1;
            check_output($sformatf("vec%0d_finished", i), 32'(finished), 32'd1);
            check_output($sformatf("vec%0d_done_pulses", i), 32'(done_total - d0), 32'(vecs[i].exp_done));
            check_output($sformatf("vec%0d_error_pulses", i), 32'(err_total - e0), 32'(!vecs[i].exp_done));
            check_output($sformatf("vec%0d_err_code", i), 32'(err_code), 32'(vecs[i].exp_code));
            check_output($sformatf("vec%0d_op_sends", i), 32'(op_sends), 32'(vecs[i].exp_op_sends));
            check_output($sformatf("vec%0d_arg_sends", i), 32'(arg_sends), 32'(vecs[i].exp_arg_sends));
            check_output($sformatf("vec%0d_bad_bytes", i), 32'(bad_bytes), 32'd0);
            check_output($sformatf("vec%0d_no_forward", i), 32'(fwd_total - f0), 32'd0);
            @(negedge clock);
        end

        // ENABLE left unanswered must fail exactly ACK_TIMEOUT cycles after the transmit.
        start_cmd(2'b11, 8'h00);
        wait_send("ack_timeout");
        pulse_sent();
        cyc = 0;
        while (!error && cyc < 500) begin
            @(negedge clock);
            cyc++;
        end
        check_output("ack_timeout_cycles", 32'(cyc), 32'd100);
        check_output("ack_timeout_code", 32'(err_code), 32'd2);
        check_output("ack_timeout_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clock);

        start_cmd(2'b11, 8'h00);
        wait_send("tx_fail");
        error_communication_timed_out = 1'b1;
        @(negedge clock);
        error_communication_timed_out = 1'b0;
        check_output("tx_fail_error", 32'(error), 32'd1);
        check_output("tx_fail_code", 32'(err_code), 32'd1);
        repeat (2) @(negedge clock);

        // A scan byte inside the ACK wait is forwarded; the ACK itself is not.
        start_cmd(2'b11, 8'h00);
        wait_send("scan_fwd");
        pulse_sent();
        send_byte(8'h1D);
        check_output("scan_fwd_en", 32'(key_byte_en), 32'd1);
        check_output("scan_fwd_byte", 32'(key_byte), 32'h1D);
        check_output("scan_fwd_still_busy", 32'(busy), 32'd1);
        send_byte(8'hFA);
        check_output("scan_fwd_done", 32'(done), 32'd1);
        check_output("scan_fwd_ack_consumed", 32'(key_byte_en), 32'd0);
        @(negedge clock);
        send_byte(8'hFA);
        check_output("idle_fa_fwd_en", 32'(key_byte_en), 32'd1);
        check_output("idle_fa_fwd_byte", 32'(key_byte), 32'hFA);
        @(negedge clock);

        // FA arriving together with command_was_sent is forwarded, not taken as the ACK.
        start_cmd(2'b11, 8'h00);
        wait_send("simul");
        command_was_sent = 1'b1;
        received_data    = 8'hFA;
        received_data_en = 1'b1;
        @(negedge clock);
        command_was_sent = 1'b0;
        received_data_en = 1'b0;
        check_output("simul_fwd_en", 32'(key_byte_en), 32'd1);
        check_output("simul_fwd_byte", 32'(key_byte), 32'hFA);
        check_output("simul_not_done", {30'd0, busy, done}, 32'd2);
        send_byte(8'hFA);
        check_output("simul_then_done", 32'(done), 32'd1);
        repeat (2) @(negedge clock);

        // Reset in the middle of the argument ACK wait.
        start_cmd(2'b00, 8'h07);
        wait_send("mid_reset_op");
        pulse_sent();
        @(negedge clock);
        send_byte(8'hFA);
        wait_send("mid_reset_arg");
        check_output("mid_reset_arg_byte", 32'(the_command), 32'h07);
        pulse_sent();
        @(negedge clock);
        check_output("mid_reset_busy_before", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        check_output("mid_reset_outputs", {28'd0, send_command, busy, done, error}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        start_cmd(2'b00, 8'h07);
        check_output("after_reset_send", 32'(send_command), 32'd1);
        check_output("after_reset_opcode", 32'(the_command), 32'hED);
        repeat (3) @(negedge clock);

        check_output("done_error_overlap", 32'(overlap), 32'd0);
        check_output("pulse_back_to_back", 32'(back_to_back), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
